// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, fetch FSM states, fetch-buffer entry.
package cpu_pkg;

    localparam int InstAddrBus = 16;
    localparam int InstBus     = 16;

    localparam logic [InstBus-1:0]     ZeroWord        = '0;
    localparam logic [InstAddrBus-1:0] BootAddrDefault = 16'h0000;

    // IDLE: no request; REQ: live request; DROP: request whose reply is discarded
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Fetch buffer: circular FIFO of {pc, inst}; flush wins over push/pop.
// Head reads as all-zero when empty. DEPTH must be a power of two (2 or 4).
module if_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointer/count bookkeeping; pointers wrap naturally at power-of-two depth
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head entry, masked to zero when nothing is buffered
    always_comb begin
        head  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
        count = cnt_q;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one-outstanding-request memory FSM feeding a small
// fetch buffer towards decode. Redirect flushes the buffer and restarts fetch;
// a reply already in flight at redirect time is discarded via the DROP state.
// Optional: define IF_FETCH_COUNT_EN to add the fetch_cnt pop counter port.
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] BOOT_ADDR = BootAddrDefault,
    parameter logic [15:0] PC_STEP   = 16'h0001,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [15:0] if_pc,
    output logic [15:0] if_inst
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [15:0]      pc_q, pc_d;              // address of current/next request
    logic [15:0]      drop_addr_q, drop_addr_d; // address held while draining
    logic             push, pop, has_space;
    logic [CNT_W-1:0] fifo_cnt;
    fetch_entry_t     head;
    int               occ_after;

    // Buffer handshakes: redirect suppresses both push and pop
    always_comb begin
        pop       = if_valid & id_ready & ~redirect;
        push      = (state_q == FETCH_REQ) & imem_ack & ~redirect;
        occ_after = int'(fifo_cnt) + (push ? 1 : 0) - (pop ? 1 : 0);
        has_space = occ_after < BUF_DEPTH;
    end

    if_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{pc: imem_addr, inst: imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_cnt)
    );

    // FSM and fetch-address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= BOOT_ADDR;
            drop_addr_q <= BOOT_ADDR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Next state: issue only when the reply is guaranteed a free slot
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            FETCH_IDLE: begin
                if (redirect) begin
                    state_d = FETCH_REQ;
                    pc_d    = redirect_pc;
                end else if (has_space) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!imem_ack) begin
                        // reply still owed for the old address: drain it
                        state_d     = FETCH_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = has_space ? FETCH_REQ : FETCH_IDLE;
                end
            end
            FETCH_DROP: begin
                if (redirect) pc_d = redirect_pc;
                if (imem_ack) state_d = FETCH_REQ;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Outputs: request held stable across wait cycles, head of buffer to decode
    always_comb begin
        imem_req  = (state_q != FETCH_IDLE);
        imem_addr = (state_q == FETCH_DROP) ? drop_addr_q : pc_q;
        if_valid  = (fifo_cnt != '0);
        if_pc     = head.pc;
        if_inst   = head.inst;
    end

`ifdef IF_FETCH_COUNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    // Retired-fetch counter: one per accepted pop, survives redirects
    always_comb begin
        fetch_cnt_d = pop ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fetch_cnt_q <= '0;
        else      fetch_cnt_q <= fetch_cnt_d;
    end

    assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_if_fetch;

    localparam logic [15:0] BOOT  = 16'h0000;
    localparam logic [15:0] STEP  = 16'h0001;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_inst;
`ifdef IF_FETCH_COUNT_EN
    logic [15:0] fetch_cnt;
`endif

    if_fetch #(.BOOT_ADDR(BOOT), .PC_STEP(STEP), .BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend, m_drop;
    logic [15:0] m_req_addr, m_next_pc;
    int          m_pops;

    function automatic void model_reset();
        mq.delete();
        m_pend = 0; m_drop = 0;
        m_req_addr = BOOT; m_next_pc = BOOT;
        m_pops = 0;
    endfunction

    function automatic void model_update(input bit idr, input bit redir,
                                         input logic [15:0] rpc, input bit ack);
        bit hs = ack && m_pend;
        if (redir) begin
            mq.delete();
            if (m_pend && !hs) begin
                m_drop = 1; m_next_pc = rpc;
            end else begin
                m_pend = 1; m_drop = 0; m_req_addr = rpc; m_next_pc = rpc;
            end
        end else begin
            if (mq.size() != 0 && idr) begin
                mq.delete(0);
                m_pops++;
            end
            if (hs) begin
                if (m_drop) begin
                    m_drop = 0; m_req_addr = m_next_pc;
                end else begin
                    mq.push_back('{m_req_addr, mem_word(m_req_addr)});
                    m_next_pc = m_req_addr + STEP;
                    if (mq.size() < DEPTH) m_req_addr = m_next_pc;
                    else m_pend = 0;
                end
            end else if (!m_pend && mq.size() < DEPTH) begin
                m_pend = 1; m_req_addr = m_next_pc;
            end
        end
    endfunction

    task automatic model_check();
        chk("imem_req", 32'(imem_req), 32'(m_pend));
        if (m_pend) chk("imem_addr", 32'(imem_addr), 32'(m_req_addr));
        chk("if_valid", 32'(if_valid), 32'(mq.size() != 0));
        chk("if_pc", 32'(if_pc), (mq.size() != 0) ? 32'(mq[0].pc) : 32'h0);
        chk("if_inst", 32'(if_inst), (mq.size() != 0) ? 32'(mq[0].inst) : 32'h0);
`ifdef IF_FETCH_COUNT_EN
        chk("fetch_cnt", 32'(fetch_cnt), 32'(m_pops[15:0]));
`endif
    endtask

    // memory responder: lat >= 0 fixed wait cycles, lat < 0 random
    int lat  = 0;
    int wcnt = 0;

    // One clock: called at posedge+1, returns at next posedge+1
    task automatic step(input bit idr, input bit redir, input logic [15:0] rpc,
                        input bit force_ack);
        bit a;
        id_ready = idr; redirect = redir; redirect_pc = rpc;
        if (force_ack) a = 1;
        else if (imem_req) a = (lat < 0) ? bit'($urandom_range(0, 1)) : (wcnt >= lat);
        else a = 0;
        if (imem_req && !a) wcnt++; else wcnt = 0;
        imem_ack = a;
        @(negedge clk);
        model_check();
        model_update(idr, redir, rpc, a);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; imem_ack = 0; redirect = 0; id_ready = 0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'(BOOT));
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", 32'(if_pc), 32'h0);
        chk("rst_if_inst", 32'(if_inst), 32'h0);
`ifdef IF_FETCH_COUNT_EN
        chk("rst_fetch_cnt", 32'(fetch_cnt), 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        wcnt = 0;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          idr;
        bit          req;
        logic [15:0] addr;
        bit          vld;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit          seen;
        logic [15:0] prev;
        logic [15:0] popped[$];

        // startup, stall to full, resume (BUF_DEPTH = 2, zero-wait memory)
        tbl[0] = '{1, 0, 16'h0000, 0, 16'h0000};
        tbl[1] = '{1, 1, 16'h0000, 0, 16'h0000};
        tbl[2] = '{1, 1, 16'h0001, 1, 16'h0000};
        tbl[3] = '{0, 1, 16'h0002, 1, 16'h0001};
        tbl[4] = '{0, 0, 16'h0000, 1, 16'h0001};
        tbl[5] = '{0, 0, 16'h0000, 1, 16'h0001};
        tbl[6] = '{1, 0, 16'h0000, 1, 16'h0001};
        tbl[7] = '{1, 1, 16'h0003, 1, 16'h0002};
        tbl[8] = '{1, 1, 16'h0004, 1, 16'h0003};

        #1;
        lat = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_vld", i), 32'(if_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_pc", i), 32'(if_pc), 32'(tbl[i].pc));
                chk($sformatf("tbl%0d_inst", i), 32'(if_inst), 32'(mem_word(tbl[i].pc)));
            end
            step(tbl[i].idr, 0, 16'h0, 0);
        end

        // long stall: buffer fills to depth, request drops, no loss on resume
        repeat (10) step(0, 0, 16'h0, 0);
        chk("stall_req_low", 32'(imem_req), 32'h0);
        popped.delete();
        for (int i = 0; i < 12; i++) begin
            if (if_valid) popped.push_back(if_pc);
            step(1, 0, 16'h0, 0);
        end
        chk("stall_pop_count", 32'(popped.size()), 32'd12);
        for (int i = 1; i < popped.size(); i++)
            chk("stall_pop_order", 32'(popped[i]), 32'(popped[i-1] + STEP));

        // redirect during a 3-cycle wait: old reply dropped, refetch at 0x0040
        lat = 3;
        do_reset();
        step(1, 0, 16'h0, 0);
        step(1, 1, 16'h0040, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (if_valid) begin
                chk("drop_first_pc", 32'(if_pc), 32'h0040);
                seen = 1;
            end
            step(1, 0, 16'h0, 0);
        end
        chk("drop_first_seen", 32'(seen), 32'h1);

        // two redirects while draining: the later target wins
        lat = 4;
        do_reset();
        step(1, 0, 16'h0, 0);
        step(1, 1, 16'h0200, 0);
        step(1, 1, 16'h0300, 0);
        seen = 0;
        for (int i = 0; i < 25 && !seen; i++) begin
            if (if_valid) begin
                chk("drop2_first_pc", 32'(if_pc), 32'h0300);
                seen = 1;
            end
            step(1, 0, 16'h0, 0);
        end
        chk("drop2_first_seen", 32'(seen), 32'h1);

        // redirect with same-cycle ack and pop
        lat = 0;
        do_reset();
        repeat (4) step(1, 0, 16'h0, 0);
        chk("redir_pre_valid", 32'(if_valid & imem_req), 32'h1);
        step(1, 1, 16'h0100, 0);
        chk("redir_empty", 32'(if_valid), 32'h0);
        chk("redir_addr", 32'(imem_addr), 32'h0100);
        repeat (3) step(1, 0, 16'h0, 0);

        // address wrap at 0xFFFF
        step(1, 1, 16'hFFFF, 0);
        popped.delete();
        for (int i = 0; i < 6; i++) begin
            if (if_valid) popped.push_back(if_pc);
            step(1, 0, 16'h0, 0);
        end
        chk("wrap_n", 32'(popped.size() >= 3), 32'h1);
        if (popped.size() >= 3) begin
            chk("wrap_pc0", 32'(popped[0]), 32'hFFFF);
            chk("wrap_pc1", 32'(popped[1]), 32'h0000);
            chk("wrap_pc2", 32'(popped[2]), 32'h0001);
        end

        // reset mid-request, late ack right after release
        lat = 2;
        repeat (3) step(1, 0, 16'h0, 0);
        chk("midreq_pending", 32'(imem_req), 32'h1);
        do_reset();
        step(1, 0, 16'h0, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (if_valid) begin
                chk("rst_first_pc", 32'(if_pc), 32'(BOOT));
                chk("rst_first_inst", 32'(if_inst), 32'(mem_word(BOOT)));
                seen = 1;
            end
            step(1, 0, 16'h0, 0);
        end
        chk("rst_first_seen", 32'(seen), 32'h1);

        // randomized traffic
        lat = -1;
        for (int i = 0; i < 1500; i++) begin
            bit          r   = ($urandom_range(0, 15) == 0);
            logic [15:0] rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            step(bit'($urandom_range(0, 3) != 0), r, rpc, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
